alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single datapath ALU and its operand-source mux between two requesters.
  - Requester 0: main execute stage.
  - Requester 1: branch/address-calc unit.
- Arbitrates round-robin and latches the winner's operands.
- Drives the ALU operand, ALU_Src and opcode controls for a fixed number of cycles, then returns the result with a one-cycle valid pulse to the winner.

Parameters:
- REGISTER_DATA_BIT_WIDTH, 16, width of register operands and ALU result.
- DATA_2_WIDTH, 4, width of the immediate operand, before sign extension by the mux.
- OP_WIDTH, 4, ALU opcode width.
- ALU_LATENCY, 1, cycles that ALU inputs must be held before alu_result is valid; legal values are 1 or more.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_0  input  1  requester 0 wants an ALU operation.
- a_0  input  REGISTER_DATA_BIT_WIDTH  requester 0 register operand A.
- b_0  input  REGISTER_DATA_BIT_WIDTH  requester 0 register operand B.
- imm_0  input  DATA_2_WIDTH  requester 0 immediate.
- src_0  input  1  requester 0 ALU_Src: 1 = immediate, 0 = operand B.
- op_0  input  OP_WIDTH  requester 0 opcode.
- req_1, a_1, b_1, imm_1, src_1, op_1  input  same widths  requester 1 equivalents.
- gnt_0, gnt_1  output  1  one-cycle grant pulse: operands captured.
- rsp_valid_0, rsp_valid_1  output  1  one-cycle result-valid pulse.
- result  output  REGISTER_DATA_BIT_WIDTH  last captured ALU result; shared by both requesters.
- alu_data_a  output  REGISTER_DATA_BIT_WIDTH  to ALU operand A.
- alu_data_1  output  REGISTER_DATA_BIT_WIDTH  to mux data_1 (operand B).
- alu_data_2  output  DATA_2_WIDTH  to mux data_2 (immediate).
- alu_src  output  1  to mux ALU_Src.
- alu_op  output  OP_WIDTH  to ALU opcode.
- alu_start  output  1  pulse in the first cycle of an operation.
- alu_result  input  REGISTER_DATA_BIT_WIDTH  ALU output.
- busy  output  1  high while not IDLE.

Behaviour:
- Reset values:
  - State IDLE; all outputs 0; result 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
  - Latency counter 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - At an edge with any req high, select a winner.
    - Only one requester high: that requester wins.
    - Both high: the requester other than last_grant wins.
  - At that same edge:
    - Capture the winner's a/b/imm/src/op into internal registers.
    - Set gnt_winner = 1 and alu_start = 1, both for one cycle.
    - Set last_grant = winner and counter = ALU_LATENCY-1.
    - Go to BUSY.
- BUSY:
  - alu_data_a / alu_data_1 / alu_data_2 / alu_src / alu_op drive the latched values, stable for all ALU_LATENCY cycles.
  - Outside BUSY these outputs are 0.
  - Counter decrements each cycle.
  - At the edge where counter == 0:
    - result <= alu_result.
    - rsp_valid_winner = 1 for one cycle.
    - Go to DONE.
- DONE: one cycle; rsp_valid pulse visible; unconditionally go to IDLE. No arbitration occurs in DONE.
- Timing:
  - First req-high edge to gnt: gnt is visible the next cycle.
  - First req-high edge to rsp_valid: visible ALU_LATENCY+1 cycles after that edge.
  - Back-to-back throughput: one operation per ALU_LATENCY+2 cycles.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - Drop req in the cycle gnt is seen, or keep it high to request again.
  - A req still high on return to IDLE is a new request. It wins immediately unless the other requester is also high and eligible under round-robin.
- Immediate handling: imm is passed unextended; sign extension is the mux's job.
- result holds its value until the next capture.
- Simultaneous events: req changes during BUSY/DONE are ignored until IDLE.
- Reset mid-operation:
  - Operation abandoned; no rsp_valid and no further gnt.
  - Everything returns to reset values on the next cycle.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 0 always wins ties.
  - last_grant is not used in the winner decision.
  - Requester 1 is served only when req_0 is low in IDLE.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then req_0=1, a_0=16'h0005, imm_0=4'hF, src_0=1, op_0=ADD, alu_result modelled as A+sext(imm):
  - gnt_0 pulses the next cycle.
  - alu_src=1 and alu_data_2=4'hF during BUSY.
  - rsp_valid_0 pulses with result=16'h0004.
- req_0 and req_1 both high continuously, ALU_LATENCY=1:
  - Grants alternate 0,1,0,1.
  - gnt spacing is 3 cycles.
  - Each rsp_valid goes only to the matching requester.
- ALU_LATENCY=3, src_1=0, b_1=16'h1234:
  - alu_data_1=16'h1234 held for exactly 3 cycles.
  - rsp_valid_1 appears 4 cycles after the req edge.
  - busy high for 4 cycles.
- rst asserted in the second BUSY cycle:
  - No rsp_valid.
  - All outputs 0 the next cycle.
  - Then req_0 and req_1 together -> gnt_0 first.
- Operands changed during BUSY (a_0 toggled): alu_data_a unchanged; result reflects the captured operands.
- With ALU_ARB_FIXED_PRIO_EN, both reqs held high: gnt_0 every grant; gnt_1 never asserts until req_0 drops.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU and its operand-source mux between two
// requesters (0 = execute stage, 1 = branch/address-calc unit).
// Round-robin arbitration by default; define ALU_ARB_FIXED_PRIO_EN to give
// requester 0 fixed priority on ties.
module alu_arbiter #(
   parameter int REGISTER_DATA_BIT_WIDTH = 16,
   parameter int DATA_2_WIDTH            = 4,
   parameter int OP_WIDTH                = 4,
   parameter int ALU_LATENCY             = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_0,
   input  logic [REGISTER_DATA_BIT_WIDTH-1:0] a_0,
   input  logic [REGISTER_DATA_BIT_WIDTH-1:0] b_0,
   input  logic [DATA_2_WIDTH-1:0]            imm_0,
   input  logic                               src_0,
   input  logic [OP_WIDTH-1:0]                op_0,
   input  logic                               req_1,
   input  logic [REGISTER_DATA_BIT_WIDTH-1:0] a_1,
   input  logic [REGISTER_DATA_BIT_WIDTH-1:0] b_1,
   input  logic [DATA_2_WIDTH-1:0]            imm_1,
   input  logic                               src_1,
   input  logic [OP_WIDTH-1:0]                op_1,
   output logic                               gnt_0,
   output logic                               gnt_1,
   output logic                               rsp_valid_0,
   output logic                               rsp_valid_1,
   output logic [REGISTER_DATA_BIT_WIDTH-1:0] result,
   output logic [REGISTER_DATA_BIT_WIDTH-1:0] alu_data_a,
   output logic [REGISTER_DATA_BIT_WIDTH-1:0] alu_data_1,
   output logic [DATA_2_WIDTH-1:0]            alu_data_2,
   output logic                               alu_src,
   output logic [OP_WIDTH-1:0]                alu_op,
   output logic                               alu_start,
   input  logic [REGISTER_DATA_BIT_WIDTH-1:0] alu_result,
   output logic                               busy
);

   localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                               state, state_nxt;
   logic [CNT_W-1:0]                     cnt;
   logic                                 last_grant;
   logic                                 winner;
   logic [REGISTER_DATA_BIT_WIDTH-1:0]   a_q, b_q;
   logic [DATA_2_WIDTH-1:0]              imm_q;
   logic                                 src_q;
   logic [OP_WIDTH-1:0]                  op_q;
   logic                                 any_req;
   logic                                 pick;

   // Winner selection for an IDLE edge (1 = requester 1).
   always_comb begin
      any_req = req_0 | req_1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      pick = ~req_0;
`else
      pick = (req_0 & req_1) ? ~last_grant : req_1;
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and output decode; grant/start are derived from the first
   // BUSY cycle (counter still at its load value) instead of extra flops.
   always_comb begin
      state_nxt   = state;
      gnt_0       = 1'b0;
      gnt_1       = 1'b0;
      rsp_valid_0 = 1'b0;
      rsp_valid_1 = 1'b0;
      alu_start   = 1'b0;
      alu_data_a  = '0;
      alu_data_1  = '0;
      alu_data_2  = '0;
      alu_src     = 1'b0;
      alu_op      = '0;
      busy        = (state != IDLE);
      case (state)
         IDLE: begin
            if (any_req) state_nxt = BUSY;
         end
         BUSY: begin
            alu_data_a = a_q;
            alu_data_1 = b_q;
            alu_data_2 = imm_q;
            alu_src    = src_q;
            alu_op     = op_q;
            alu_start  = (cnt == CNT_INIT);
            gnt_0      = alu_start & ~winner;
            gnt_1      = alu_start & winner;
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            rsp_valid_0 = ~winner;
            rsp_valid_1 = winner;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, latency counter, round-robin pointer and result.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         last_grant <= 1'b1;
         winner     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         imm_q      <= '0;
         src_q      <= 1'b0;
         op_q       <= '0;
         result     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  winner     <= pick;
                  last_grant <= pick;
                  cnt        <= CNT_INIT;
                  a_q        <= pick ? a_1   : a_0;
                  b_q        <= pick ? b_1   : b_0;
                  imm_q      <= pick ? imm_1 : imm_0;
                  src_q      <= pick ? src_1 : src_0;
                  op_q       <= pick ? op_1  : op_0;
               end
            end
            BUSY: begin
               if (cnt == '0) result <= alu_result;
               else           cnt    <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. A behavioural ALU
// sits on the ALU ports; a transaction-level model predicts grants,
// responses, driven operands and results. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
   localparam int W = 16, IW = 4, OW = 4, LAT = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Main DUT (ALU_LATENCY = 1)
   logic          rst, req_0, src_0, req_1, src_1;
   logic [W-1:0]  a_0, b_0, a_1, b_1;
   logic [IW-1:0] imm_0, imm_1;
   logic [OW-1:0] op_0, op_1;
   logic          gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, alu_src, alu_start, busy;
   logic [W-1:0]  result, alu_data_a, alu_data_1, alu_result;
   logic [IW-1:0] alu_data_2;
   logic [OW-1:0] alu_op;

   // Second DUT (ALU_LATENCY = 3)
   logic          x_rst, x_req_0, x_src_0, x_req_1, x_src_1;
   logic [W-1:0]  x_a_0, x_b_0, x_a_1, x_b_1;
   logic [IW-1:0] x_imm_0, x_imm_1;
   logic [OW-1:0] x_op_0, x_op_1;
   logic          x_gnt_0, x_gnt_1, x_rsp_valid_0, x_rsp_valid_1, x_alu_src, x_alu_start, x_busy;
   logic [W-1:0]  x_result, x_alu_data_a, x_alu_data_1, x_alu_result;
   logic [IW-1:0] x_alu_data_2;
   logic [OW-1:0] x_alu_op;

   alu_arbiter #(.REGISTER_DATA_BIT_WIDTH(W), .DATA_2_WIDTH(IW), .OP_WIDTH(OW), .ALU_LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req_0(req_0), .a_0(a_0), .b_0(b_0), .imm_0(imm_0), .src_0(src_0), .op_0(op_0),
      .req_1(req_1), .a_1(a_1), .b_1(b_1), .imm_1(imm_1), .src_1(src_1), .op_1(op_1),
      .gnt_0(gnt_0), .gnt_1(gnt_1), .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .result(result), .alu_data_a(alu_data_a), .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
      .alu_src(alu_src), .alu_op(alu_op), .alu_start(alu_start), .alu_result(alu_result), .busy(busy)
   );

   alu_arbiter #(.REGISTER_DATA_BIT_WIDTH(W), .DATA_2_WIDTH(IW), .OP_WIDTH(OW), .ALU_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(x_rst),
      .req_0(x_req_0), .a_0(x_a_0), .b_0(x_b_0), .imm_0(x_imm_0), .src_0(x_src_0), .op_0(x_op_0),
      .req_1(x_req_1), .a_1(x_a_1), .b_1(x_b_1), .imm_1(x_imm_1), .src_1(x_src_1), .op_1(x_op_1),
      .gnt_0(x_gnt_0), .gnt_1(x_gnt_1), .rsp_valid_0(x_rsp_valid_0), .rsp_valid_1(x_rsp_valid_1),
      .result(x_result), .alu_data_a(x_alu_data_a), .alu_data_1(x_alu_data_1), .alu_data_2(x_alu_data_2),
      .alu_src(x_alu_src), .alu_op(x_alu_op), .alu_start(x_alu_start), .alu_result(x_alu_result), .busy(x_busy)
   );

   // Datapath ALU: op 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, else pass A.
   function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b,
                                             logic [IW-1:0] imm, logic src, logic [OW-1:0] op);
      logic [W-1:0] o;
      o = src ? {{(W-IW){imm[IW-1]}}, imm} : b;
      case (op)
         4'd0:    return a + o;
         4'd1:    return a - o;
         4'd2:    return a & o;
         4'd3:    return a | o;
         4'd4:    return a ^ o;
         default: return a;
      endcase
   endfunction

   always_comb alu_result   = ref_alu(alu_data_a, alu_data_1, alu_data_2, alu_src, alu_op);
   always_comb x_alu_result = ref_alu(x_alu_data_a, x_alu_data_1, x_alu_data_2, x_alu_src, x_alu_op);

   // Transaction-level model of the main DUT.
   int            cyc = 0;
   int            m_next_arb = 0;
   logic          m_last = 1'b1;
   bit            m_has = 0;
   int            m_g = 0;
   logic          m_w = 1'b0;
   logic [W-1:0]  m_a, m_b, m_res;
   logic [W-1:0]  m_result = '0;
   logic [IW-1:0] m_imm;
   logic          m_src;
   logic [OW-1:0] m_op;
   logic          e_gnt0, e_gnt1, e_rsp0, e_rsp1, e_busy, e_start, e_src;
   logic [W-1:0]  e_a, e_b;
   logic [IW-1:0] e_imm;
   logic [OW-1:0] e_op;

   task automatic tick();
      bit   was_rst;
      bit   inb, dn;
      logic w;
      was_rst = rst;
      if (!rst && (cyc + 1 >= m_next_arb) && (req_0 || req_1)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         w = !req_0;
`else
         if (req_0 && req_1) w = !m_last;
         else                w = req_1;
`endif
         m_has = 1; m_g = cyc + 1; m_w = w;
         m_a   = w ? a_1   : a_0;
         m_b   = w ? b_1   : b_0;
         m_imm = w ? imm_1 : imm_0;
         m_src = w ? src_1 : src_0;
         m_op  = w ? op_1  : op_0;
         m_res = ref_alu(m_a, m_b, m_imm, m_src, m_op);
         m_last = w;
         m_next_arb = m_g + LAT + 2;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (was_rst) begin
         m_has = 0; m_last = 1'b1; m_next_arb = cyc + 1; m_result = '0;
      end
      inb = m_has && cyc >= m_g && cyc < m_g + LAT;
      dn  = m_has && cyc == m_g + LAT;
      e_busy  = inb || dn;
      e_start = m_has && cyc == m_g;
      e_gnt0  = e_start && !m_w;
      e_gnt1  = e_start && m_w;
      e_rsp0  = dn && !m_w;
      e_rsp1  = dn && m_w;
      if (dn) m_result = m_res;
      e_a   = inb ? m_a   : '0;
      e_b   = inb ? m_b   : '0;
      e_imm = inb ? m_imm : '0;
      e_src = inb ? m_src : 1'b0;
      e_op  = inb ? m_op  : '0;
   endtask

   task automatic new_ops0();
      a_0 = W'($urandom); b_0 = W'($urandom); imm_0 = IW'($urandom);
      src_0 = 1'($urandom_range(0, 1)); op_0 = OW'($urandom_range(0, 5));
   endtask

   task automatic new_ops1();
      a_1 = W'($urandom); b_1 = W'($urandom); imm_1 = IW'($urandom);
      src_1 = 1'($urandom_range(0, 1)); op_1 = OW'($urandom_range(0, 5));
   endtask

   task automatic test_reset();
      rst = 1'b1; req_0 = 0; req_1 = 0;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, busy, alu_start, alu_src} !== 7'b0) begin
         errors++; $display("FAIL reset_ctl got=%b exp=0", {gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, busy, alu_start, alu_src});
      end
      checks++;
      if ({alu_data_a, alu_data_1, alu_data_2, alu_op, result} !== '0) begin
         errors++; $display("FAIL reset_data a=%h b=%h imm=%h op=%h res=%h exp=0", alu_data_a, alu_data_1, alu_data_2, alu_op, result);
      end
   endtask

   task automatic test_imm_add();
      req_0 = 1; a_0 = 16'h0005; b_0 = W'($urandom); imm_0 = 4'hF; src_0 = 1; op_0 = 4'd0;
      req_1 = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 1) begin
            checks++;
            if ({gnt_0, gnt_1, alu_start, busy} !== 4'b1011) begin
               errors++; $display("FAIL imm_gnt got=%b exp=1011", {gnt_0, gnt_1, alu_start, busy});
            end
            checks++;
            if ({alu_src, alu_data_2, alu_data_a} !== {1'b1, 4'hF, 16'h0005}) begin
               errors++; $display("FAIL imm_ops src=%b imm=%h a=%h exp src=1 imm=f a=0005", alu_src, alu_data_2, alu_data_a);
            end
            req_0 = 0;
         end
         if (k == 2) begin
            checks++;
            if ({rsp_valid_0, rsp_valid_1, gnt_0, result} !== {3'b100, 16'h0004}) begin
               errors++; $display("FAIL imm_rsp rsp0=%b rsp1=%b gnt0=%b res=%h exp 1 0 0 0004", rsp_valid_0, rsp_valid_1, gnt_0, result);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int   g_at[$];
      logic g_who[$];
      bit   dropped0, g1_after_drop;
      new_ops0(); new_ops1();
      req_0 = 1; req_1 = 1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         checks++;
         if ({gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, busy} !== {e_gnt0, e_gnt1, e_rsp0, e_rsp1, e_busy}) begin
            errors++; $display("FAIL b2b_ctl k=%0d got=%b exp=%b", k, {gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, busy}, {e_gnt0, e_gnt1, e_rsp0, e_rsp1, e_busy});
         end
         if (gnt_0 || gnt_1) begin g_at.push_back(k); g_who.push_back(gnt_1); end
      end
      checks++;
      if (g_at.size() != 4) begin
         errors++; $display("FAIL b2b_count got=%0d exp=4", g_at.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (g_at[i] - g_at[i-1] != 3) begin
               errors++; $display("FAIL b2b_spacing i=%0d got=%0d exp=3", i, g_at[i] - g_at[i-1]);
            end
            checks++;
`ifdef ALU_ARB_FIXED_PRIO_EN
            if (g_who[i] !== 1'b0) begin
               errors++; $display("FAIL b2b_prio i=%0d got=%b exp=0", i, g_who[i]);
            end
`else
            if (g_who[i] !== ~g_who[i-1]) begin
               errors++; $display("FAIL b2b_alternate i=%0d got=%b exp=%b", i, g_who[i], ~g_who[i-1]);
            end
`endif
         end
      end
      // requester 0 leaves once served; requester 1 must then be granted
      dropped0 = 0; g1_after_drop = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if ({gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, busy} !== {e_gnt0, e_gnt1, e_rsp0, e_rsp1, e_busy}) begin
            errors++; $display("FAIL b2b_tail_ctl k=%0d got=%b exp=%b", k, {gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, busy}, {e_gnt0, e_gnt1, e_rsp0, e_rsp1, e_busy});
         end
         if (dropped0 && gnt_1) g1_after_drop = 1;
         if (e_gnt0) begin req_0 = 0; dropped0 = 1; end
         if (e_gnt1 && dropped0) req_1 = 0;
      end
      checks++;
      if (!g1_after_drop) begin
         errors++; $display("FAIL b2b_serve1 got=0 exp=1");
      end
      req_0 = 0; req_1 = 0;
      repeat (4) tick();
   endtask

   task automatic test_hold_operands();
      logic [W-1:0] a_orig, exp_res;
      new_ops0(); src_0 = 0; req_0 = 1; req_1 = 0;
      a_orig = a_0;
      exp_res = ref_alu(a_0, b_0, imm_0, src_0, op_0);
      tick();
      a_0 = ~a_0; req_0 = 0;
      #1;
      checks++;
      if (gnt_0 !== 1'b1 || alu_data_a !== a_orig) begin
         errors++; $display("FAIL hold_a gnt0=%b a=%h exp gnt0=1 a=%h", gnt_0, alu_data_a, a_orig);
      end
      tick();
      checks++;
      if (rsp_valid_0 !== 1'b1 || result !== exp_res) begin
         errors++; $display("FAIL hold_res rsp0=%b res=%h exp rsp0=1 res=%h", rsp_valid_0, result, exp_res);
      end
      repeat (2) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick();
         checks++;
         if ({gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, busy, alu_start} !== {e_gnt0, e_gnt1, e_rsp0, e_rsp1, e_busy, e_start}) begin
            errors++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", cyc, {gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, busy, alu_start}, {e_gnt0, e_gnt1, e_rsp0, e_rsp1, e_busy, e_start});
         end
         checks++;
         if ({alu_data_a, alu_data_1, alu_data_2, alu_src, alu_op} !== {e_a, e_b, e_imm, e_src, e_op}) begin
            errors++; $display("FAIL rand_ops cyc=%0d got=%h/%h/%h/%b/%h exp=%h/%h/%h/%b/%h", cyc, alu_data_a, alu_data_1, alu_data_2, alu_src, alu_op, e_a, e_b, e_imm, e_src, e_op);
         end
         checks++;
         if (result !== m_result) begin
            errors++; $display("FAIL rand_result cyc=%0d got=%h exp=%h", cyc, result, m_result);
         end
         // requesters hold while waiting; after a grant they may leave or re-request
         if (!req_0) begin
            if ($urandom_range(0, 1) == 1) begin req_0 = 1; new_ops0(); end
         end else if (e_gnt0) begin
            req_0 = 1'($urandom_range(0, 1));
            new_ops0();
         end
         if (!req_1) begin
            if ($urandom_range(0, 1) == 1) begin req_1 = 1; new_ops1(); end
         end else if (e_gnt1) begin
            req_1 = 1'($urandom_range(0, 1));
            new_ops1();
         end
         rst = ($urandom_range(0, 59) == 0);
      end
      rst = 0; req_0 = 0; req_1 = 0;
      repeat (4) tick();
   endtask

   task automatic test_latency3();
      logic [W-1:0] ta, rsp_res;
      int hold, busy_n, gnt_at, rsp_at, rsp0_n;
      x_rst = 1;
      repeat (2) @(posedge clk);
      #1;
      x_rst = 0;
      ta = W'($urandom);
      x_req_1 = 1; x_a_1 = ta; x_b_1 = 16'h1234; x_src_1 = 0; x_op_1 = 4'd0; x_imm_1 = IW'($urandom);
      hold = 0; busy_n = 0; gnt_at = 0; rsp_at = 0; rsp0_n = 0; rsp_res = '0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (x_gnt_1 && gnt_at == 0) gnt_at = k;
         if (x_gnt_1) x_req_1 = 0;
         if (x_alu_data_1 === 16'h1234) hold++;
         if (x_busy) busy_n++;
         if (x_rsp_valid_0) rsp0_n++;
         if (x_rsp_valid_1 && rsp_at == 0) begin rsp_at = k; rsp_res = x_result; end
      end
      checks++;
      if (gnt_at != 1) begin errors++; $display("FAIL lat3_gnt got=%0d exp=1", gnt_at); end
      checks++;
      if (hold != 3) begin errors++; $display("FAIL lat3_hold got=%0d exp=3", hold); end
      checks++;
      if (rsp_at != 4) begin errors++; $display("FAIL lat3_rsp_at got=%0d exp=4", rsp_at); end
      checks++;
      if (busy_n != 4) begin errors++; $display("FAIL lat3_busy got=%0d exp=4", busy_n); end
      checks++;
      if (rsp_res !== ta + 16'h1234 || rsp0_n != 0) begin
         errors++; $display("FAIL lat3_result got=%h rsp0=%0d exp=%h rsp0=0", rsp_res, rsp0_n, ta + 16'h1234);
      end
   endtask

   task automatic test_reset_mid();
      int rsp_n;
      rsp_n = 0;
      x_req_1 = 1; x_a_1 = W'($urandom); x_b_1 = W'($urandom); x_src_1 = 0; x_op_1 = 4'd0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         if (x_rsp_valid_0 || x_rsp_valid_1) rsp_n++;
         if (k == 1) x_req_1 = 0;
         if (k == 2) begin
            checks++;
            if (x_busy !== 1'b1 || x_alu_start !== 1'b0) begin
               errors++; $display("FAIL rstmid_busy2 busy=%b start=%b exp busy=1 start=0", x_busy, x_alu_start);
            end
            x_rst = 1;
         end
      end
      checks++;
      if ({x_gnt_0, x_gnt_1, x_rsp_valid_0, x_rsp_valid_1, x_busy, x_alu_start, x_alu_src,
           x_alu_data_a, x_alu_data_1, x_alu_data_2, x_alu_op, x_result} !== '0) begin
         errors++; $display("FAIL rstmid_zero busy=%b a=%h b=%h res=%h exp all 0", x_busy, x_alu_data_a, x_alu_data_1, x_result);
      end
      checks++;
      if (rsp_n != 0) begin errors++; $display("FAIL rstmid_norsp got=%0d exp=0", rsp_n); end
      x_rst = 0;
      x_req_0 = 1; x_a_0 = W'($urandom); x_b_0 = W'($urandom); x_src_0 = 0; x_op_0 = 4'd1;
      x_req_1 = 1;
      @(posedge clk);
      #1;
      checks++;
      if ({x_gnt_0, x_gnt_1} !== 2'b10) begin
         errors++; $display("FAIL rstmid_first got=%b exp=10", {x_gnt_0, x_gnt_1});
      end
      x_req_0 = 0; x_req_1 = 0;
      repeat (6) @(posedge clk);
   endtask

   initial begin
      rst = 1; req_0 = 0; req_1 = 0;
      a_0 = '0; b_0 = '0; imm_0 = '0; src_0 = 0; op_0 = '0;
      a_1 = '0; b_1 = '0; imm_1 = '0; src_1 = 0; op_1 = '0;
      x_rst = 1; x_req_0 = 0; x_req_1 = 0;
      x_a_0 = '0; x_b_0 = '0; x_imm_0 = '0; x_src_0 = 0; x_op_0 = '0;
      x_a_1 = '0; x_b_1 = '0; x_imm_1 = '0; x_src_1 = 0; x_op_1 = '0;
      test_reset();
      test_imm_add();
      test_back_to_back();
      test_hold_operands();
      test_random();
      test_latency3();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
